// File: rtl/wait_cycles_1_1.sv
// Programmable cycle delay for the Bream call protocol: a start request loads
// a down-counter, and result/result_ready report completion until the next start.
module wait_cycles_1_1 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] cycles,
    output logic [W-1:0] result,
    output logic         result_ready,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] remaining_q, remaining_d;
    logic [W-1:0] lat_q, lat_d;
    logic [W-1:0] result_q, result_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            lat_q       <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lat_q       <= lat_d;
            result_q    <= result_d;
        end
    end

    // A start on any edge wins over counting; result is preserved across
    // a non-zero reload so an aborted wait leaves the old answer visible.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        lat_d       = lat_q;
        result_d    = result_q;

        if (start) begin
            remaining_d = cycles;
            lat_d       = cycles;
            if (cycles != '0) begin
                state_d = COUNT;
            end else begin
                state_d  = DONE;
                result_d = '0;
            end
        end else begin
            case (state_q)
                COUNT: begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - 1'b1;
                    end
                    if (remaining_q <= 1) begin
                        state_d  = DONE;
                        result_d = lat_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result       = result_q;
    assign result_ready = (state_q == DONE) && !start;
    assign busy         = (state_q == COUNT);

endmodule

// File: tb/tb_wait_cycles_1_1.sv
// Directed bench for wait_cycles_1_1: a 16-bit instance for the main scenarios
// and a 4-bit instance for the full-range boundary.
module tb_wait_cycles_1_1;

    logic        clk;
    logic        reset_n;

    logic        start16;
    logic [15:0] cycles16;
    logic [15:0] result16;
    logic        ready16;
    logic        busy16;

    logic        start4;
    logic [3:0]  cycles4;
    logic [3:0]  result4;
    logic        ready4;
    logic        busy4;

    int errors = 0;
    int checks = 0;

    wait_cycles_1_1 #(.W(16)) dut16 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start16),
        .cycles       (cycles16),
        .result       (result16),
        .result_ready (ready16),
        .busy         (busy16)
    );

    wait_cycles_1_1 #(.W(4)) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start4),
        .cycles       (cycles4),
        .result       (result4),
        .result_ready (ready4),
        .busy         (busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled while clk is low.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic s, input logic [15:0] c);
        start16  = s;
        cycles16 = c;
    endtask

    initial begin
        reset_n  = 1'b0;
        start16  = 1'b0;
        cycles16 = '0;
        start4   = 1'b0;
        cycles4  = '0;
        #12;
        checkOutput("reset_ready", ready16, 0);
        checkOutput("reset_busy", busy16, 0);
        checkOutput("reset_result", result16, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("idle_no_ready", ready16, 0);
        checkOutput("idle_no_busy", busy16, 0);

        // Basic delay of 5
        applyStimulus(1'b1, 16'd5);
        tick();
        applyStimulus(1'b0, 16'd99);
        for (int i = 1; i <= 4; i++) begin
            checkOutput($sformatf("basic_busy_%0d", i), busy16, 1);
            checkOutput($sformatf("basic_noready_%0d", i), ready16, 0);
            tick();
        end
        checkOutput("basic_busy_5", busy16, 1);
        tick();
        checkOutput("basic_ready", ready16, 1);
        checkOutput("basic_result", result16, 5);
        checkOutput("basic_busy_done", busy16, 0);
        tick();
        tick();
        checkOutput("basic_ready_held", ready16, 1);
        checkOutput("basic_result_held", result16, 5);
        start16 = 1'b1;
        #1;
        checkOutput("ready_masked_by_start", ready16, 0);

        // Zero cycles
        cycles16 = 16'd0;
        tick();
        checkOutput("zero_ready_while_start", ready16, 0);
        start16 = 1'b0;
        #1;
        checkOutput("zero_ready", ready16, 1);
        checkOutput("zero_result", result16, 0);
        checkOutput("zero_busy", busy16, 0);
        @(negedge clk);

        // One cycle
        applyStimulus(1'b1, 16'd1);
        tick();
        start16 = 1'b0;
        #1;
        checkOutput("one_noready", ready16, 0);
        checkOutput("one_busy", busy16, 1);
        tick();
        checkOutput("one_ready", ready16, 1);
        checkOutput("one_result", result16, 1);

        // Start held for 3 edges with cycles=4
        applyStimulus(1'b1, 16'd4);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("held_noready_%0d", i), ready16, 0);
        end
        applyStimulus(1'b0, 16'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput($sformatf("held_count_noready_%0d", i), ready16, 0);
        end
        tick();
        checkOutput("held_ready", ready16, 1);
        checkOutput("held_result", result16, 4);

        // Restart mid-count: 20 then 2
        applyStimulus(1'b1, 16'd20);
        tick();
        applyStimulus(1'b0, 16'd0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            checkOutput($sformatf("restart_noready_%0d", i), ready16, 0);
        end
        checkOutput("restart_busy", busy16, 1);
        applyStimulus(1'b1, 16'd2);
        tick();
        applyStimulus(1'b0, 16'd0);
        #1;
        checkOutput("restart_result_kept", result16, 4);
        tick();
        checkOutput("restart_noready_mid", ready16, 0);
        tick();
        checkOutput("restart_ready", ready16, 1);
        checkOutput("restart_result", result16, 2);

        // Asynchronous reset mid-count
        applyStimulus(1'b1, 16'd10);
        tick();
        applyStimulus(1'b0, 16'd0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("rst_precount_busy", busy16, 1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", busy16, 0);
        checkOutput("async_rst_ready", ready16, 0);
        checkOutput("async_rst_result", result16, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checkOutput("post_rst_noready", ready16, 0);
        checkOutput("post_rst_nobusy", busy16, 0);

        // Full-range boundary on the 4-bit instance
        start4  = 1'b1;
        cycles4 = 4'd15;
        tick();
        start4  = 1'b0;
        cycles4 = 4'd3;
        for (int i = 1; i <= 14; i++) tick();
        checkOutput("w4_busy_14", busy4, 1);
        checkOutput("w4_noready_14", ready4, 0);
        tick();
        checkOutput("w4_ready", ready4, 1);
        checkOutput("w4_result", result4, 15);
        checkOutput("w4_busy_done", busy4, 0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("w4_ready_held", ready4, 1);
        checkOutput("w4_busy_held", busy4, 0);
        checkOutput("w4_result_held", result4, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
